// File: rtl/hi_xcorr_mode_ctrl_pkg.sv
// Shared encodings and defaults for the HF reader-side correlator mode controller.
// Holds the state encoding, cfg_mode bit positions and the default timing parameters.
package hi_xcorr_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARM   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam int MODE_IS_848      = 0;
  localparam int MODE_SNOOP       = 1;
  localparam int MODE_CARRIER_OFF = 2;

  localparam int DEF_SETTLE_RPTS  = 2;
  localparam int DEF_CARRIER_WAIT = 1024;
  localparam int DEF_WDOG_CYCLES  = 4095;

  // Snoop listens to someone else's field, so our own carrier stays off.
  function automatic logic carrier_for_mode(input logic [2:0] mode);
    return ~mode[MODE_CARRIER_OFF] & ~mode[MODE_SNOOP];
  endfunction

endpackage

// File: rtl/hi_xcorr_wdog.sv
// Saturating 12-bit cycle counter with clear, enable and a threshold hit flag.
// Used for both the carrier warm-up wait and the report-strobe watchdog.
module hi_xcorr_wdog (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [11:0] i_thresh,
  output logic        o_hit
);

  logic [11:0] r_cnt;
  logic [12:0] w_next;

  assign w_next = {1'b0, r_cnt} + 13'd1;
  // Hit on the enabled cycle that completes i_thresh counted cycles.
  assign o_hit  = i_en & (w_next >= {1'b0, i_thresh});

  // Count enabled cycles, holding at all-ones rather than wrapping
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 12'd0;
    end else if (i_clr) begin
      r_cnt <= 12'd0;
    end else if (i_en && (r_cnt != 12'hFFF)) begin
      r_cnt <= w_next[11:0];
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/hi_xcorr_mode_ctrl.sv
// Correlator mode sequencer: latches ARM mode requests and applies them only on report
// boundaries, mutes SSP while the correlator settles, and flags a stalled report stream.
module hi_xcorr_mode_ctrl
  import hi_xcorr_mode_ctrl_pkg::*;
#(
  parameter int SETTLE_RPTS  = DEF_SETTLE_RPTS,
  parameter int CARRIER_WAIT = DEF_CARRIER_WAIT,
  parameter int WDOG_CYCLES  = DEF_WDOG_CYCLES
) (
  input  logic       ck_1356megb,
  input  logic       reset_n,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_mode,
  output logic       cfg_ready,
  input  logic       rpt_strobe,
  output logic       xcorr_is_848,
  output logic       snoop,
  output logic       carrier_en,
  output logic       ssp_mute,
  output logic       stall,
  output logic [1:0] state_o
);

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_RPTS);
  localparam logic [11:0] CARRIER_THR = 12'(CARRIER_WAIT);
  localparam logic [11:0] WDOG_THR    = 12'(WDOG_CYCLES);

  state_e      r_state;
  logic        r_pend_valid;
  logic [2:0]  r_pend_mode;
  logic [3:0]  r_settle_cnt;
  logic        r_is_848;
  logic        r_snoop;
  logic        r_carrier_en;
  logic        r_ssp_mute;
  logic        r_stall;
  logic        r_cfg_ready;

  logic        w_accept;
  logic        w_run_apply;
  logic        w_cnt_en;
  logic        w_cnt_clr;
  logic        w_cnt_hit;
  logic [11:0] w_cnt_thr;

  assign w_accept    = cfg_valid & r_cfg_ready;
  assign w_run_apply = rpt_strobe & r_pend_valid;
  assign w_cnt_clr   = ~w_cnt_en;

  // Counter runs through carrier warm-up and between report strobes in RUN
  always_comb begin
    w_cnt_en  = 1'b0;
    w_cnt_thr = WDOG_THR;
    case (r_state)
      ST_WARM: begin
        w_cnt_en  = ~r_snoop;
        w_cnt_thr = CARRIER_THR;
      end
      ST_RUN: begin
        w_cnt_en  = ~rpt_strobe;
        w_cnt_thr = WDOG_THR;
      end
      default: begin
        w_cnt_en  = 1'b0;
        w_cnt_thr = WDOG_THR;
      end
    endcase
  end

  hi_xcorr_wdog u_wdog (
    .i_clk    (ck_1356megb),
    .i_rst_n  (reset_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .i_thresh (w_cnt_thr),
    .o_hit    (w_cnt_hit)
  );

  // Mode sequencer with pending-request register and registered outputs
  always_ff @(negedge ck_1356megb or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_mode  <= 3'd0;
      r_settle_cnt <= 4'd0;
      r_is_848     <= 1'b0;
      r_snoop      <= 1'b0;
      r_carrier_en <= 1'b0;
      r_ssp_mute   <= 1'b1;
      r_stall      <= 1'b0;
      r_cfg_ready  <= 1'b1;
    end else begin
      // Outside IDLE a request waits for a report boundary.
      if (w_accept && (r_state != ST_IDLE)) begin
        r_pend_valid <= 1'b1;
        r_pend_mode  <= cfg_mode;
        r_cfg_ready  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          r_ssp_mute <= 1'b1;
          if (w_accept) begin
            r_is_848     <= cfg_mode[MODE_IS_848];
            r_snoop      <= cfg_mode[MODE_SNOOP];
            r_carrier_en <= carrier_for_mode(cfg_mode);
            r_state      <= cfg_mode[MODE_CARRIER_OFF] ? ST_IDLE : ST_WARM;
          end
        end
        ST_WARM: begin
          if (r_snoop || w_cnt_hit) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (rpt_strobe) begin
            if (r_settle_cnt <= 4'd1) begin
              r_settle_cnt <= 4'd0;
              r_state      <= ST_RUN;
              r_ssp_mute   <= 1'b0;
            end else begin
              r_settle_cnt <= r_settle_cnt - 4'd1;
            end
          end
        end
        ST_RUN: begin
          if (w_run_apply) begin
            r_is_848     <= r_pend_mode[MODE_IS_848];
            r_snoop      <= r_pend_mode[MODE_SNOOP];
            r_carrier_en <= carrier_for_mode(r_pend_mode);
            r_pend_valid <= 1'b0;
            r_cfg_ready  <= 1'b1;
            r_ssp_mute   <= 1'b1;
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= r_pend_mode[MODE_CARRIER_OFF] ? ST_IDLE : ST_SETTLE;
          end else if (w_cnt_hit) begin
            r_stall      <= 1'b1;
            r_ssp_mute   <= 1'b1;
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= ST_SETTLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready    = r_cfg_ready;
  assign xcorr_is_848 = r_is_848;
  assign snoop        = r_snoop;
  assign carrier_en   = r_carrier_en;
  assign ssp_mute     = r_ssp_mute;
  assign stall        = r_stall;
  assign state_o      = r_state;

endmodule

// File: tb/tb_hi_xcorr_mode_ctrl.sv
// Bench for hi_xcorr_mode_ctrl: hand-derived vector table, reset corner case, then
// random stimulus against a counting/queue reference model of the sequencing rules.
module tb_hi_xcorr_mode_ctrl;

  localparam int SR = 2;
  localparam int CW = 1024;
  localparam int WD = 4095;

  logic       ck;
  logic       reset_n;
  logic       cfg_valid;
  logic [2:0] cfg_mode;
  logic       cfg_ready;
  logic       rpt_strobe;
  logic       xcorr_is_848;
  logic       snoop;
  logic       carrier_en;
  logic       ssp_mute;
  logic       stall;
  logic [1:0] state_o;

  int n_total = 0;
  int n_bad   = 0;

  hi_xcorr_mode_ctrl #(
    .SETTLE_RPTS  (SR),
    .CARRIER_WAIT (CW),
    .WDOG_CYCLES  (WD)
  ) dut (
    .ck_1356megb  (ck),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_mode     (cfg_mode),
    .cfg_ready    (cfg_ready),
    .rpt_strobe   (rpt_strobe),
    .xcorr_is_848 (xcorr_is_848),
    .snoop        (snoop),
    .carrier_en   (carrier_en),
    .ssp_mute     (ssp_mute),
    .stall        (stall),
    .state_o      (state_o)
  );

  initial ck = 1'b1;
  always #5 ck = ~ck;

  // Reference model: phase 0..3 = IDLE/WARM/SETTLE/RUN, counts kept as plain ints.
  int         m_phase;
  int         m_warm;
  int         m_left;
  int         m_quiet;
  logic       m_ready, m_848, m_snoop, m_car, m_mute, m_stall;
  logic [2:0] m_pend[$];

  task automatic model_reset();
    m_phase = 0; m_warm = 0; m_left = 0; m_quiet = 0;
    m_ready = 1'b1; m_848 = 1'b0; m_snoop = 1'b0; m_car = 1'b0;
    m_mute = 1'b1; m_stall = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_apply(input logic [2:0] md);
    m_848   = md[0];
    m_snoop = md[1];
    m_car   = !md[2] && !md[1];
    m_mute  = 1'b1;
  endtask

  task automatic model_step(input logic v, input logic [2:0] md, input logic s);
    logic       acc;
    int         ph0;
    logic [2:0] pm;
    acc = v && m_ready;
    ph0 = m_phase;
    case (m_phase)
      0: begin
        if (acc) begin
          model_apply(md);
          if (!md[2]) begin m_phase = 1; m_warm = 0; end
        end
      end
      1: begin
        m_warm++;
        if (m_snoop || m_warm >= CW) begin m_phase = 2; m_left = SR; end
      end
      2: begin
        if (s) begin
          m_left--;
          if (m_left == 0) begin m_phase = 3; m_mute = 1'b0; m_quiet = 0; end
        end
      end
      default: begin
        if (s && m_pend.size() > 0) begin
          pm = m_pend.pop_front();
          model_apply(pm);
          m_ready = 1'b1;
          if (pm[2]) m_phase = 0;
          else begin m_phase = 2; m_left = SR; end
        end else if (s) begin
          m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet >= WD) begin
            m_stall = 1'b1; m_mute = 1'b1; m_phase = 2; m_left = SR;
          end
        end
      end
    endcase
    if (acc && ph0 != 0) begin
      m_pend.push_back(md);
      m_ready = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_pack();
    return {2'(m_phase), m_ready, m_848, m_snoop, m_car, m_mute, m_stall};
  endfunction

  function automatic logic [7:0] dut_pack();
    return {state_o, cfg_ready, xcorr_is_848, snoop, carrier_en, ssp_mute, stall};
  endfunction

  // Packed order: state[1:0] cfg_ready is_848 snoop carrier_en ssp_mute stall
  task automatic check(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = dut_pack();
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One active (negative) clock edge; outputs sampled on the following posedge.
  task automatic tick(input logic v, input logic [2:0] md, input logic s);
    cfg_valid  = v;
    cfg_mode   = md;
    rpt_strobe = s;
    model_step(v, md, s);
    @(negedge ck);
    @(posedge ck);
    cfg_valid  = 1'b0;
    rpt_strobe = 1'b0;
    check("model", model_pack());
  endtask

  typedef struct {
    int         extra;
    logic       v;
    logic [2:0] m;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[24];
  logic       rv, rs;
  logic [2:0] rm;

  initial begin
    tbl[0]  = '{0,    1'b1, 3'b000, 1'b0, 8'b01_1_0_0_1_1_0};
    tbl[1]  = '{1022, 1'b0, 3'b000, 1'b0, 8'b01_1_0_0_1_1_0};
    tbl[2]  = '{0,    1'b0, 3'b000, 1'b0, 8'b10_1_0_0_1_1_0};
    tbl[3]  = '{0,    1'b0, 3'b000, 1'b1, 8'b10_1_0_0_1_1_0};
    tbl[4]  = '{0,    1'b0, 3'b000, 1'b1, 8'b11_1_0_0_1_0_0};
    tbl[5]  = '{0,    1'b1, 3'b001, 1'b0, 8'b11_0_0_0_1_0_0};
    tbl[6]  = '{5,    1'b0, 3'b000, 1'b0, 8'b11_0_0_0_1_0_0};
    tbl[7]  = '{0,    1'b0, 3'b000, 1'b1, 8'b10_1_1_0_1_1_0};
    tbl[8]  = '{0,    1'b0, 3'b000, 1'b1, 8'b10_1_1_0_1_1_0};
    tbl[9]  = '{0,    1'b0, 3'b000, 1'b1, 8'b11_1_1_0_1_0_0};
    tbl[10] = '{0,    1'b1, 3'b100, 1'b1, 8'b11_0_1_0_1_0_0};
    tbl[11] = '{0,    1'b0, 3'b000, 1'b1, 8'b00_1_0_0_0_1_0};
    tbl[12] = '{0,    1'b1, 3'b010, 1'b0, 8'b01_1_0_1_0_1_0};
    tbl[13] = '{0,    1'b0, 3'b000, 1'b0, 8'b10_1_0_1_0_1_0};
    tbl[14] = '{0,    1'b0, 3'b000, 1'b1, 8'b10_1_0_1_0_1_0};
    tbl[15] = '{0,    1'b0, 3'b000, 1'b1, 8'b11_1_0_1_0_0_0};
    tbl[16] = '{0,    1'b0, 3'b000, 1'b1, 8'b11_1_0_1_0_0_0};
    tbl[17] = '{4093, 1'b0, 3'b000, 1'b0, 8'b11_1_0_1_0_0_0};
    tbl[18] = '{0,    1'b0, 3'b000, 1'b0, 8'b10_1_0_1_0_1_1};
    tbl[19] = '{0,    1'b0, 3'b000, 1'b1, 8'b10_1_0_1_0_1_1};
    tbl[20] = '{0,    1'b0, 3'b000, 1'b1, 8'b11_1_0_1_0_0_1};
    tbl[21] = '{0,    1'b1, 3'b011, 1'b0, 8'b11_0_0_1_0_0_1};
    tbl[22] = '{0,    1'b0, 3'b000, 1'b1, 8'b10_1_1_1_0_1_1};
    tbl[23] = '{0,    1'b1, 3'b000, 1'b0, 8'b10_0_1_1_0_1_1};

    reset_n    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_mode   = 3'b000;
    rpt_strobe = 1'b0;
    model_reset();
    @(posedge ck);
    check("reset", 8'b00_1_0_0_0_1_0);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      tick(tbl[i].v, tbl[i].m, tbl[i].s);
      for (int k = 0; k < tbl[i].extra; k++) tick(1'b0, 3'b000, 1'b0);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Async reset while SETTLE holds a pending request: request must be dropped.
    #2 reset_n = 1'b0;
    #1 check("async_rst", 8'b00_1_0_0_0_1_0);
    model_reset();
    @(posedge ck);
    @(posedge ck);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) tick(1'b0, 3'b000, 1'b1);
    check("post_rst_idle", 8'b00_1_0_0_0_1_0);
    tick(1'b1, 3'b101, 1'b0);
    check("idle_carrier_off", 8'b00_1_1_0_0_1_0);

    for (int i = 0; i < 6000; i++) begin
      rv = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 5) == 0);
      rm = 3'($urandom_range(0, 7));
      tick(rv, rm, rs);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
